// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the three request/response channels that meet at mem_arbiter:
//   imem  : fetch request (val/addr/rdy) and fetch response (val/data)
//   dmem  : data request (val/type/addr/wdata/rdy) and data response (val/data)
//   mem   : unified memory request (val/type/addr/wdata/rdy) and response (val/data)
//   modport slave  : the arbiter's view
//   modport master : the environment's view (core ports plus memory)
interface mem_arbiter_if;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic        imemreq_rdy;
  logic        imemresp_val;
  logic [31:0] imemresp_data;

  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic        dmemreq_rdy;
  logic        dmemresp_val;
  logic [31:0] dmemresp_data;

  logic        memreq_val;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memreq_rdy;
  logic        memresp_val;
  logic [31:0] memresp_data;

  modport slave (
    input  imemreq_val, imemreq_addr,
    output imemreq_rdy, imemresp_val, imemresp_data,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output dmemreq_rdy, dmemresp_val, dmemresp_data,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata,
    input  memreq_rdy, memresp_val, memresp_data
  );

  modport master (
    output imemreq_val, imemreq_addr,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  dmemreq_rdy, dmemresp_val, dmemresp_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata,
    output memreq_rdy, memresp_val, memresp_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one in-order memory between the instruction-fetch (imem) and data
//   (dmem) ports. dmem wins conflicts unless imem has lost MAX_WAIT cycles in
//   a row. Owners of accepted requests are kept in an in-order tag queue and
//   each memory response is routed back to its owner.
//   Ports:
//     clk : clock
//     rst : synchronous reset, active low
//     bus : mem_arbiter_if.slave (imem, dmem and memory channels)
module mem_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [DEPTH-1:0] tags_q, tags_d;   // 0 = imem, 1 = dmem
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;

  logic full, sel_i, sel_d, fire, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign sel_i = bus.imemreq_val & (~bus.dmemreq_val | (wcnt_q == WW'(MAX_WAIT)));
  assign sel_d = bus.dmemreq_val & ~sel_i;

  assign bus.memreq_val   = (sel_i | sel_d) & ~full & rst;
  assign bus.memreq_type  = sel_d & bus.dmemreq_type;
  assign bus.memreq_addr  = sel_d ? bus.dmemreq_addr : bus.imemreq_addr;
  assign bus.memreq_wdata = bus.dmemreq_wdata;

  assign bus.imemreq_rdy = sel_i & ~full & bus.memreq_rdy & rst;
  assign bus.dmemreq_rdy = sel_d & ~full & bus.memreq_rdy & rst;
  assign fire            = bus.memreq_val & bus.memreq_rdy;

  // A response with nothing outstanding is dropped without touching state.
  assign head = tags_q[rptr_q];
  assign pop  = bus.memresp_val & (cnt_q != '0) & rst;

  assign bus.imemresp_val  = pop & ~head;
  assign bus.dmemresp_val  = pop & head;
  assign bus.imemresp_data = bus.memresp_data;
  assign bus.dmemresp_data = bus.memresp_data;

  always_comb begin
    tags_d = tags_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    wcnt_d = wcnt_q;

    if (fire) begin
      tags_d[wptr_q] = sel_d;
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case ({fire, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (~bus.imemreq_val | (fire & sel_i)) begin
      wcnt_d = '0;
    end else if (wcnt_q != WW'(MAX_WAIT)) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tags_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
    end else begin
      tags_q <= tags_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      wcnt_q <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios with literal expectations, then randomized traffic.
//   Every cycle the DUT outputs are compared against a queue-based model of
//   the arbitration, tag ordering and wait-counter rules.
module tb_mem_arbiter;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model state: owners of outstanding requests (0 imem, 1 dmem) and the
  // number of consecutive cycles imem has been waiting.
  bit tagq[$];
  int wait_cnt = 0;
  bit m_iacc = 1'b0;
  bit m_dacc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model for the current cycle, then advance
  // the model to the state after the coming clock edge.
  task automatic model_step();
    bit full, si, sd, mv, ir, dr, fire, pop, iresp, dresp;
    if (!rst) begin
      chk("rst memreq_val", 32'(bus.memreq_val), 32'd0);
      chk("rst imemreq_rdy", 32'(bus.imemreq_rdy), 32'd0);
      chk("rst dmemreq_rdy", 32'(bus.dmemreq_rdy), 32'd0);
      chk("rst imemresp_val", 32'(bus.imemresp_val), 32'd0);
      chk("rst dmemresp_val", 32'(bus.dmemresp_val), 32'd0);
      tagq.delete();
      wait_cnt = 0;
      m_iacc = 1'b0;
      m_dacc = 1'b0;
      return;
    end
    full = (tagq.size() == DEPTH);
    si   = bus.imemreq_val && (!bus.dmemreq_val || wait_cnt == MAX_WAIT);
    sd   = bus.dmemreq_val && !si;
    mv   = (si || sd) && !full;
    ir   = si && mv && bus.memreq_rdy;
    dr   = sd && mv && bus.memreq_rdy;
    fire = ir || dr;
    pop  = bus.memresp_val && tagq.size() != 0;
    iresp = pop && tagq[0] == 1'b0;
    dresp = pop && tagq[0] == 1'b1;

    chk("memreq_val", 32'(bus.memreq_val), 32'(mv));
    chk("imemreq_rdy", 32'(bus.imemreq_rdy), 32'(ir));
    chk("dmemreq_rdy", 32'(bus.dmemreq_rdy), 32'(dr));
    if (mv) begin
      chk("memreq_addr", bus.memreq_addr, si ? bus.imemreq_addr : bus.dmemreq_addr);
      chk("memreq_type", 32'(bus.memreq_type), si ? 32'd0 : 32'(bus.dmemreq_type));
      if (sd) chk("memreq_wdata", bus.memreq_wdata, bus.dmemreq_wdata);
    end
    chk("imemresp_val", 32'(bus.imemresp_val), 32'(iresp));
    chk("dmemresp_val", 32'(bus.dmemresp_val), 32'(dresp));
    if (iresp) chk("imemresp_data", bus.imemresp_data, bus.memresp_data);
    if (dresp) chk("dmemresp_data", bus.dmemresp_data, bus.memresp_data);

    if (pop) void'(tagq.pop_front());
    if (fire) tagq.push_back(dr);
    if (!bus.imemreq_val || ir) wait_cnt = 0;
    else if (wait_cnt < MAX_WAIT) wait_cnt++;
    m_iacc = ir;
    m_dacc = dr;
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit iv, input logic [31:0] ia, input bit dv, input bit dt,
                        input logic [31:0] da, input logic [31:0] dw, input bit mr,
                        input bit rv, input logic [31:0] rd);
    bus.imemreq_val   = iv;
    bus.imemreq_addr  = ia;
    bus.dmemreq_val   = dv;
    bus.dmemreq_type  = dt;
    bus.dmemreq_addr  = da;
    bus.dmemreq_wdata = dw;
    bus.memreq_rdy    = mr;
    bus.memresp_val   = rv;
    bus.memresp_data  = rd;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Reset with everything asserted: no val/rdy may leak out.
    set_in(1, 32'h10, 1, 1, 32'h20, 32'h30, 1, 1, 32'h40);
    chk("reset memreq_val", 32'(bus.memreq_val), 32'd0);
    chk("reset imemresp_val", 32'(bus.imemresp_val), 32'd0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;

    // Lone fetch.
    set_in(1, 32'h200, 0, 0, 0, 0, 1, 0, 0);
    chk("fetch memreq_val", 32'(bus.memreq_val), 32'd1);
    chk("fetch memreq_addr", bus.memreq_addr, 32'h200);
    chk("fetch memreq_type", 32'(bus.memreq_type), 32'd0);
    chk("fetch imemreq_rdy", 32'(bus.imemreq_rdy), 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
    chk("fetch imemresp_val", 32'(bus.imemresp_val), 32'd1);
    chk("fetch imemresp_data", bus.imemresp_data, 32'hDEADBEEF);
    chk("fetch dmemresp_val", 32'(bus.dmemresp_val), 32'd0);
    step();

    // Conflict: dmem wins four cycles, imem forced on the fifth.
    for (int unsigned c = 1; c <= 5; c++) begin
      set_in(1, 32'h300, 1, 1, 32'h100, 32'h5, 1, 1, 32'h1000 + c);
      if (c < 5) begin
        chk("conflict dmemreq_rdy", 32'(bus.dmemreq_rdy), 32'd1);
        chk("conflict imemreq_rdy", 32'(bus.imemreq_rdy), 32'd0);
      end else begin
        chk("starve imemreq_rdy", 32'(bus.imemreq_rdy), 32'd1);
        chk("starve dmemreq_rdy", 32'(bus.dmemreq_rdy), 32'd0);
        chk("starve memreq_addr", bus.memreq_addr, 32'h300);
      end
      if (c == 1) begin
        chk("conflict memreq_type", 32'(bus.memreq_type), 32'd1);
        chk("conflict memreq_wdata", bus.memreq_wdata, 32'h5);
        chk("conflict stray dmemresp", 32'(bus.dmemresp_val), 32'd0);
      end
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 32'h66);
    chk("conflict drain imemresp", 32'(bus.imemresp_val), 32'd1);
    step();

    // Full queue, no bypass, then in-order routing.
    set_in(1, 32'h400, 0, 0, 0, 0, 1, 0, 0);
    step();
    set_in(1, 32'h404, 0, 0, 0, 0, 1, 0, 0);
    step();
    set_in(1, 32'h408, 1, 0, 32'h500, 0, 1, 1, 32'h11);
    chk("full memreq_val", 32'(bus.memreq_val), 32'd0);
    chk("full imemreq_rdy", 32'(bus.imemreq_rdy), 32'd0);
    chk("full dmemreq_rdy", 32'(bus.dmemreq_rdy), 32'd0);
    step();
    set_in(1, 32'h408, 1, 0, 32'h500, 0, 1, 0, 0);
    chk("after pop dmemreq_rdy", 32'(bus.dmemreq_rdy), 32'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 32'hA);
    chk("order first imemresp", 32'(bus.imemresp_val), 32'd1);
    chk("order first data", bus.imemresp_data, 32'hA);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 32'hB);
    chk("order second dmemresp", 32'(bus.dmemresp_val), 32'd1);
    chk("order second imemresp", 32'(bus.imemresp_val), 32'd0);
    chk("order second data", bus.dmemresp_data, 32'hB);
    step();

    // Reset with a request in flight; the late response must be dropped.
    set_in(1, 32'h600, 0, 0, 0, 0, 1, 0, 0);
    step();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 32'h77);
    chk("post-reset imemresp", 32'(bus.imemresp_val), 32'd0);
    chk("post-reset dmemresp", 32'(bus.dmemresp_val), 32'd0);
    step();
    // Count must be zero: exactly DEPTH writes accepted before stalling.
    for (int unsigned c = 0; c < 3; c++) begin
      set_in(0, 0, 1, 1, 32'h700 + c, c, 1, 0, 0);
      chk("post-reset fill rdy", 32'(bus.dmemreq_rdy), (c < DEPTH) ? 32'd1 : 32'd0);
      step();
    end
    for (int unsigned c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 32'h80 + c);
      chk("write ack dmemresp", 32'(bus.dmemresp_val), 32'd1);
      step();
    end

    // Stray response on an empty queue.
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 32'h99);
    chk("stray imemresp", 32'(bus.imemresp_val), 32'd0);
    chk("stray dmemresp", 32'(bus.dmemresp_val), 32'd0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();

    // Randomized traffic; pending requests are held until accepted.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) >= 2);
      if (!(bus.imemreq_val && !m_iacc)) begin
        bus.imemreq_val  = ($urandom_range(0, 9) < 7);
        bus.imemreq_addr = $urandom;
      end
      if (!(bus.dmemreq_val && !m_dacc)) begin
        bus.dmemreq_val   = ($urandom_range(0, 9) < 6);
        bus.dmemreq_type  = 1'($urandom_range(0, 1));
        bus.dmemreq_addr  = $urandom;
        bus.dmemreq_wdata = $urandom;
      end
      bus.memreq_rdy   = ($urandom_range(0, 3) != 0);
      bus.memresp_val  = (tagq.size() != 0) ? 1'($urandom_range(0, 1))
                                            : ($urandom_range(0, 19) == 0);
      bus.memresp_data = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
